// File: rtl/dcache_ctrl_if.sv
// Bundles the CPU-side handshake, the flush handshake and the data-memory bus of dcache_ctrl.
// master = CPU plus memory environment, slave = the cache controller.
interface dcache_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic        flush_done;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata,
        input  cpu_rdata, cpu_ready, flush_done, mem_addr, mem_wdata, mem_write,
               hit_cnt, miss_cnt
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata,
        output cpu_rdata, cpu_ready, flush_done, mem_addr, mem_wdata, mem_write,
               hit_cnt, miss_cnt
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, one-word-per-line write-back data cache controller with a flush scan
// and saturating hit/miss counters. All outputs are registered.
module dcache_ctrl #(
    parameter int LINES   = 8,
    parameter int MEM_LAT = 2
) (
    input logic          clk,
    input logic          reset,
    dcache_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 5 - IDX_W;
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LINES - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WRITEBACK, ALLOCATE, RESPOND, FLUSH
    } state_t;

    state_t           state;
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tags [LINES];
    logic [31:0]      data [LINES];

    logic             req_we;
    logic [4:0]       req_addr;
    logic [31:0]      req_wdata;
    logic             replay;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] flush_idx;

    logic [31:0] cpu_rdata_q;
    logic        cpu_ready_q;
    logic        flush_done_q;
    logic [4:0]  mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_write_q;
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             hit;
    logic             victim_dirty;
    logic [IDX_W-1:0] next_idx;
    logic             cur_dirty;
    logic             next_dirty;
    logic             unused_addr_bits;

    assign req_idx      = req_addr[IDX_W-1:0];
    assign req_tag      = req_addr[4:IDX_W];
    assign hit          = valid[req_idx] && (tags[req_idx] == req_tag);
    assign victim_dirty = valid[req_idx] && dirty[req_idx];
    assign next_idx     = flush_idx + IDX_W'(1);
    assign cur_dirty    = valid[flush_idx] && dirty[flush_idx];
    assign next_dirty   = valid[next_idx] && dirty[next_idx];

    // Only the low five address bits select a word; the rest are deliberately ignored.
    assign unused_addr_bits = ^bus.cpu_addr[31:5];

    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.flush_done = flush_done_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.hit_cnt    = hit_q;
    assign bus.miss_cnt   = miss_q;

    // Memory outputs are set up one edge ahead, so mem_write is raised on the
    // edge that starts the final cycle of each write-back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            valid        <= '0;
            dirty        <= '0;
            for (int i = 0; i < LINES; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
            req_we       <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            replay       <= 1'b0;
            cnt          <= '0;
            flush_idx    <= '0;
            cpu_rdata_q  <= '0;
            cpu_ready_q  <= 1'b0;
            flush_done_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_write_q  <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            cpu_ready_q  <= 1'b0;
            flush_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.flush) begin
                        state     <= FLUSH;
                        flush_idx <= '0;
                        cnt       <= '0;
                        if (valid[0] && dirty[0]) begin
                            mem_addr_q  <= {tags[0], IDX_W'(0)};
                            mem_wdata_q <= data[0];
                            mem_write_q <= (MEM_LAT == 1);
                        end
                    end else if (bus.cpu_req) begin
                        req_we    <= bus.cpu_we;
                        req_addr  <= bus.cpu_addr[4:0];
                        req_wdata <= bus.cpu_wdata;
                        replay    <= 1'b0;
                        state     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (!replay && hit_q != 16'hFFFF) begin
                            hit_q <= hit_q + 16'd1;
                        end
                        if (req_we) begin
                            data[req_idx]  <= req_wdata;
                            dirty[req_idx] <= 1'b1;
                        end else begin
                            cpu_rdata_q <= data[req_idx];
                        end
                        replay <= 1'b0;
                        state  <= RESPOND;
                    end else begin
                        if (miss_q != 16'hFFFF) begin
                            miss_q <= miss_q + 16'd1;
                        end
                        cnt <= '0;
                        if (victim_dirty) begin
                            mem_addr_q  <= {tags[req_idx], req_idx};
                            mem_wdata_q <= data[req_idx];
                            mem_write_q <= (MEM_LAT == 1);
                            state       <= WRITEBACK;
                        end else begin
                            mem_addr_q <= req_addr;
                            state      <= ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    if (cnt == CNT_LAST) begin
                        dirty[req_idx] <= 1'b0;
                        mem_write_q    <= 1'b0;
                        mem_wdata_q    <= '0;
                        mem_addr_q     <= req_addr;
                        cnt            <= '0;
                        state          <= ALLOCATE;
                    end else begin
                        cnt         <= cnt + CNT_W'(1);
                        mem_write_q <= ((cnt + CNT_W'(1)) == CNT_LAST);
                    end
                end
                ALLOCATE: begin
                    if (cnt == CNT_LAST) begin
                        valid[req_idx] <= 1'b1;
                        dirty[req_idx] <= 1'b0;
                        tags[req_idx]  <= req_tag;
                        data[req_idx]  <= bus.mem_rdata;
                        mem_addr_q     <= '0;
                        replay         <= 1'b1;
                        state          <= LOOKUP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESPOND: begin
                    cpu_ready_q <= 1'b1;
                    state       <= IDLE;
                end
                FLUSH: begin
                    if (cur_dirty && cnt != CNT_LAST) begin
                        cnt         <= cnt + CNT_W'(1);
                        mem_write_q <= ((cnt + CNT_W'(1)) == CNT_LAST);
                    end else begin
                        if (cur_dirty) begin
                            dirty[flush_idx] <= 1'b0;
                        end
                        cnt         <= '0;
                        mem_write_q <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        if (flush_idx == IDX_LAST) begin
                            flush_done_q <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            flush_idx <= next_idx;
                            if (next_dirty) begin
                                mem_addr_q  <= {tags[next_idx], next_idx};
                                mem_wdata_q <= data[next_idx];
                                mem_write_q <= (MEM_LAT == 1);
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed self-checking bench for dcache_ctrl (LINES=8, MEM_LAT=2) with a behavioural
// data memory that logs every write it receives.
module tb_dcache_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dcache_ctrl_if bus ();

    dcache_ctrl #(.LINES(8), .MEM_LAT(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    bit [31:0] mem_arr [32];
    bit [31:0] mem_written;
    int        wr_count = 0;
    bit [4:0]  wr_addr_log [16];
    bit [31:0] wr_data_log [16];

    function automatic logic [31:0] init_val(input logic [4:0] a);
        return (a == 5'd5) ? 32'hA5A5_A5A5 : (32'h1000_0000 | {27'd0, a});
    endfunction

    function automatic logic [31:0] mem_rd(input logic [4:0] a);
        return mem_written[a] ? mem_arr[a] : init_val(a);
    endfunction

    assign bus.mem_rdata = mem_rd(bus.mem_addr);

    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem_arr[bus.mem_addr]     <= bus.mem_wdata;
            mem_written[bus.mem_addr] <= 1'b1;
            if (wr_count < 16) begin
                wr_addr_log[wr_count] <= bus.mem_addr;
                wr_data_log[wr_count] <= bus.mem_wdata;
            end
            wr_count <= wr_count + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one access, scrambles the request inputs once accepted, and returns the
    // number of edges from the sampling edge to the one that raises cpu_ready.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  output int lat, output logic [31:0] rdata);
        logic got;
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        @(posedge clk);
        #1;
        bus.cpu_we    = ~we;
        bus.cpu_addr  = ~addr;
        bus.cpu_wdata = ~wdata;
        lat   = 0;
        rdata = '0;
        got   = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.cpu_ready) begin
                got         = 1'b1;
                rdata       = bus.cpu_rdata;
                bus.cpu_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        check_output("ready_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        int          cyc;
        int          fd_cyc;
        int          fd_count;
        int          rdy_cyc;

        reset         = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
        check_output("rst_flush_done", {31'd0, bus.flush_done}, 32'd0);
        check_output("rst_mem_write", {31'd0, bus.mem_write}, 32'd0);
        check_output("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check_output("rst_mem_addr", {27'd0, bus.mem_addr}, 32'd0);
        check_output("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check_output("rst_hit_cnt", {16'd0, bus.hit_cnt}, 32'd0);
        check_output("rst_miss_cnt", {16'd0, bus.miss_cnt}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] cold load miss");
        apply_stimulus(1'b0, 32'd5, 32'd0, lat, rd);
        check_output("cold_lat", lat, 32'd5);
        check_output("cold_rdata", rd, 32'hA5A5_A5A5);
        check_output("cold_miss_cnt", {16'd0, bus.miss_cnt}, 32'd1);
        check_output("cold_hit_cnt", {16'd0, bus.hit_cnt}, 32'd0);
        check_output("cold_no_write", wr_count, 32'd0);

        $display("[TB] store and load hits");
        apply_stimulus(1'b1, 32'd5, 32'h11, lat, rd);
        check_output("st_hit_lat", lat, 32'd2);
        apply_stimulus(1'b0, 32'hABCD_E005, 32'd0, lat, rd);
        check_output("ld_hit_lat", lat, 32'd2);
        check_output("ld_hit_rdata", rd, 32'h11);
        check_output("hits_hit_cnt", {16'd0, bus.hit_cnt}, 32'd2);
        check_output("mem5_untouched", mem_rd(5'd5), 32'hA5A5_A5A5);
        check_output("hits_no_write", wr_count, 32'd0);

        $display("[TB] dirty miss with write-back");
        apply_stimulus(1'b0, 32'd13, 32'd0, lat, rd);
        check_output("dirty_lat", lat, 32'd7);
        check_output("dirty_rdata", rd, 32'h1000_000D);
        check_output("dirty_wr_count", wr_count, 32'd1);
        check_output("dirty_wr_addr", {27'd0, wr_addr_log[0]}, 32'd5);
        check_output("dirty_wr_data", wr_data_log[0], 32'h11);
        check_output("dirty_miss_cnt", {16'd0, bus.miss_cnt}, 32'd2);
        apply_stimulus(1'b0, 32'd5, 32'd0, lat, rd);
        check_output("refill5_lat", lat, 32'd5);
        check_output("refill5_rdata", rd, 32'h11);

        $display("[TB] flush with simultaneous request");
        apply_stimulus(1'b1, 32'd1, 32'h22, lat, rd);
        check_output("st1_lat", lat, 32'd5);
        apply_stimulus(1'b1, 32'd6, 32'h66, lat, rd);
        check_output("st6_lat", lat, 32'd5);
        @(negedge clk);
        bus.flush     = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'd9;
        bus.cpu_wdata = '0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        cyc      = 0;
        fd_cyc   = -1;
        fd_count = 0;
        rdy_cyc  = -1;
        rd       = '0;
        for (int i = 0; i < 60 && rdy_cyc < 0; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.flush_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
            if (bus.cpu_ready) begin
                rdy_cyc     = cyc;
                rd          = bus.cpu_rdata;
                bus.cpu_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        check_output("flush_done_count", fd_count, 32'd1);
        check_output("flush_done_cycle", fd_cyc, 32'd10);
        check_output("flush_ready_cycle", rdy_cyc, 32'd16);
        check_output("flush_req_rdata", rd, 32'h1000_0009);
        check_output("flush_wr_count", wr_count, 32'd3);
        check_output("flush_wr0_addr", {27'd0, wr_addr_log[1]}, 32'd1);
        check_output("flush_wr0_data", wr_data_log[1], 32'h22);
        check_output("flush_wr1_addr", {27'd0, wr_addr_log[2]}, 32'd6);
        check_output("flush_wr1_data", wr_data_log[2], 32'h66);
        apply_stimulus(1'b0, 32'd6, 32'd0, lat, rd);
        check_output("post_flush_hit_lat", lat, 32'd2);
        check_output("post_flush_rdata", rd, 32'h66);
        check_output("post_flush_hit_cnt", {16'd0, bus.hit_cnt}, 32'd3);
        check_output("post_flush_miss_cnt", {16'd0, bus.miss_cnt}, 32'd6);

        $display("[TB] reset during write-back");
        apply_stimulus(1'b1, 32'd6, 32'h77, lat, rd);
        check_output("st77_lat", lat, 32'd2);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'd14;
        bus.cpu_wdata = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_output("wb1_mem_addr", {27'd0, bus.mem_addr}, 32'd6);
        check_output("wb1_mem_wdata", bus.mem_wdata, 32'h77);
        check_output("wb1_mem_write", {31'd0, bus.mem_write}, 32'd0);
        reset       = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        check_output("abort_mem_addr", {27'd0, bus.mem_addr}, 32'd0);
        check_output("abort_mem_wdata", bus.mem_wdata, 32'd0);
        check_output("abort_mem_write", {31'd0, bus.mem_write}, 32'd0);
        check_output("abort_hit_cnt", {16'd0, bus.hit_cnt}, 32'd0);
        check_output("abort_miss_cnt", {16'd0, bus.miss_cnt}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_output("abort_wr_count", wr_count, 32'd3);
        check_output("abort_mem6", mem_rd(5'd6), 32'h66);
        check_output("abort_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        apply_stimulus(1'b0, 32'd6, 32'd0, lat, rd);
        check_output("after_abort_lat", lat, 32'd5);
        check_output("after_abort_rdata", rd, 32'h66);
        check_output("after_abort_miss_cnt", {16'd0, bus.miss_cnt}, 32'd1);

        $display("[TB] hit counter saturation");
        @(negedge clk);
        force dut.hit_q = 16'hFFFE;
        @(negedge clk);
        release dut.hit_q;
        #1;
        check_output("sat_preload", {16'd0, bus.hit_cnt}, 32'h0000_FFFE);
        apply_stimulus(1'b0, 32'd6, 32'd0, lat, rd);
        check_output("sat_hit1", {16'd0, bus.hit_cnt}, 32'h0000_FFFF);
        apply_stimulus(1'b0, 32'd6, 32'd0, lat, rd);
        apply_stimulus(1'b0, 32'd6, 32'd0, lat, rd);
        check_output("sat_hit3", {16'd0, bus.hit_cnt}, 32'h0000_FFFF);
        check_output("sat_hit3_lat", lat, 32'd2);
        check_output("sat_hit3_rdata", rd, 32'h66);
        check_output("sat_miss_cnt", {16'd0, bus.miss_cnt}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
